// File: rtl/uart_rx_pkt_ctrl.sv
// Packet controller behind uart_rx. It hunts for a sync byte, collects a length-prefixed,
// XOR-checked frame into a local buffer, then drains the payload over valid/ready.
module uart_rx_pkt_ctrl #(
    parameter int          MAX_LEN        = 16,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ctrl_en,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       rx_break,
    output logic       rx_en,
    output logic [7:0] pkt_data,
    output logic       pkt_valid,
    input  logic       pkt_ready,
    output logic       pkt_last,
    output logic [7:0] pkt_len,
    output logic       err_chk,
    output logic       err_len,
    output logic       err_timeout,
    output logic       err_break,
    output logic [7:0] pkt_ok_cnt
);

    localparam int            IW        = $clog2(MAX_LEN + 1);
    localparam int            CW        = $clog2(TIMEOUT_CYCLES);
    localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HUNT    = 3'd1,
        ST_LEN     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CHK     = 3'd4,
        ST_DRAIN   = 3'd5
    } state_t;

    state_t        state_q;
    logic          rx_en_q;
    logic [7:0]    len_q;
    logic [7:0]    xor_q;
    logic [IW-1:0] wr_idx_q;
    logic [IW-1:0] rd_idx_q;
    logic [CW-1:0] to_cnt_q;
    logic [7:0]    pkt_data_q;
    logic          pkt_valid_q;
    logic          pkt_last_q;
    logic [7:0]    pkt_len_q;
    logic [7:0]    ok_cnt_q;
    logic          err_chk_q;
    logic          err_len_q;
    logic          err_timeout_q;
    logic          err_break_q;
    logic [7:0]    buf_q [2**IW];

    logic          buf_we_s;
    logic [IW-1:0] rd_nxt_s;

    assign buf_we_s = (state_q == ST_PAYLOAD) && ctrl_en && rx_valid && !rx_break;
    assign rd_nxt_s = rd_idx_q + IW'(1);

    // Payload buffer: contents need no reset, only the indices do.
    always_ff @(posedge clk) begin
        if (buf_we_s) begin
            buf_q[wr_idx_q] <= rx_data;
        end
    end

    // Frame sequencer with all outputs registered.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            rx_en_q       <= 1'b0;
            len_q         <= 8'd0;
            xor_q         <= 8'd0;
            wr_idx_q      <= '0;
            rd_idx_q      <= '0;
            to_cnt_q      <= '0;
            pkt_data_q    <= 8'd0;
            pkt_valid_q   <= 1'b0;
            pkt_last_q    <= 1'b0;
            pkt_len_q     <= 8'd0;
            ok_cnt_q      <= 8'd0;
            err_chk_q     <= 1'b0;
            err_len_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            err_break_q   <= 1'b0;
        end else begin
            err_chk_q     <= 1'b0;
            err_len_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            err_break_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (ctrl_en) begin
                        state_q <= ST_HUNT;
                        rx_en_q <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_HUNT, ST_LEN, ST_PAYLOAD, ST_CHK: begin
                    if (!ctrl_en) begin
                        state_q <= ST_IDLE;
                        rx_en_q <= 1'b0;
                    end else if (rx_valid) begin
                        // Every accepted byte restarts the inter-byte timer, including the sync byte.
                        to_cnt_q <= '0;
                        if (state_q == ST_HUNT) begin
                            if (!rx_break && (rx_data == SYNC_BYTE)) begin
                                state_q <= ST_LEN;
                            end
                        end else if (rx_break) begin
                            err_break_q <= 1'b1;
                            state_q     <= ST_HUNT;
                        end else begin
                            case (state_q)
                                ST_LEN: begin
                                    if ((rx_data == 8'd0) || (rx_data > MAX_LEN_B)) begin
                                        err_len_q <= 1'b1;
                                        state_q   <= ST_HUNT;
                                    end else begin
                                        len_q    <= rx_data;
                                        xor_q    <= rx_data;
                                        wr_idx_q <= '0;
                                        state_q  <= ST_PAYLOAD;
                                    end
                                end
                                ST_PAYLOAD: begin
                                    xor_q <= xor_q ^ rx_data;
                                    if (8'(wr_idx_q) == (len_q - 8'd1)) begin
                                        state_q <= ST_CHK;
                                    end else begin
                                        wr_idx_q <= wr_idx_q + IW'(1);
                                    end
                                end
                                ST_CHK: begin
                                    if (rx_data == xor_q) begin
                                        state_q     <= ST_DRAIN;
                                        rx_en_q     <= 1'b0;
                                        rd_idx_q    <= '0;
                                        pkt_len_q   <= len_q;
                                        pkt_valid_q <= 1'b1;
                                        pkt_data_q  <= buf_q[IW'(0)];
                                        pkt_last_q  <= (len_q == 8'd1);
                                        if (ok_cnt_q != 8'hFF) begin
                                            ok_cnt_q <= ok_cnt_q + 8'd1;
                                        end
                                    end else begin
                                        err_chk_q <= 1'b1;
                                        state_q   <= ST_HUNT;
                                    end
                                end
                                default: state_q <= ST_HUNT;
                            endcase
                        end
                    end else if (state_q == ST_HUNT) begin
                        to_cnt_q <= '0;
                    end else if (to_cnt_q == TO_LAST) begin
                        err_timeout_q <= 1'b1;
                        state_q       <= ST_HUNT;
                    end else begin
                        to_cnt_q <= to_cnt_q + CW'(1);
                    end
                end
                ST_DRAIN: begin
                    if (pkt_ready) begin
                        if (pkt_last_q) begin
                            pkt_valid_q <= 1'b0;
                            pkt_last_q  <= 1'b0;
                            state_q     <= ctrl_en ? ST_HUNT : ST_IDLE;
                            rx_en_q     <= ctrl_en;
                        end else begin
                            rd_idx_q   <= rd_nxt_s;
                            pkt_data_q <= buf_q[rd_nxt_s];
                            pkt_last_q <= (8'(rd_nxt_s) == (len_q - 8'd1));
                        end
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    rx_en_q     <= 1'b0;
                    pkt_valid_q <= 1'b0;
                    pkt_last_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_en       = rx_en_q;
    assign pkt_data    = pkt_data_q;
    assign pkt_valid   = pkt_valid_q;
    assign pkt_last    = pkt_last_q;
    assign pkt_len     = pkt_len_q;
    assign err_chk     = err_chk_q;
    assign err_len     = err_len_q;
    assign err_timeout = err_timeout_q;
    assign err_break   = err_break_q;
    assign pkt_ok_cnt  = ok_cnt_q;

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Directed bench for uart_rx_pkt_ctrl: good frames, backpressure, error frames,
// timeout, BREAK, junk skipping, enable drop and async reset during drain.
module tb_uart_rx_pkt_ctrl;

    localparam int TO = 20;

    logic       clk = 1'b0;
    logic       resetn;
    logic       ctrl_en;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_break;
    logic       rx_en;
    logic [7:0] pkt_data;
    logic       pkt_valid;
    logic       pkt_ready;
    logic       pkt_last;
    logic [7:0] pkt_len;
    logic       err_chk;
    logic       err_len;
    logic       err_timeout;
    logic       err_break;
    logic [7:0] pkt_ok_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    int n_chk = 0, n_len = 0, n_to = 0, n_brk = 0, n_valid = 0, stall_viol = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'd0;
    logic [7:0] hs_q[$];

    uart_rx_pkt_ctrl #(.MAX_LEN(16), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .resetn(resetn), .ctrl_en(ctrl_en),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_break(rx_break),
        .rx_en(rx_en), .pkt_data(pkt_data), .pkt_valid(pkt_valid),
        .pkt_ready(pkt_ready), .pkt_last(pkt_last), .pkt_len(pkt_len),
        .err_chk(err_chk), .err_len(err_len), .err_timeout(err_timeout),
        .err_break(err_break), .pkt_ok_cnt(pkt_ok_cnt)
    );

    always #5 clk = ~clk;

    // Count high cycles of each pulse output and of pkt_valid.
    always @(negedge clk) begin
        if (err_chk)     n_chk++;
        if (err_len)     n_len++;
        if (err_timeout) n_to++;
        if (err_break)   n_brk++;
        if (pkt_valid)   n_valid++;
    end

    // Log handshakes and flag any data change while stalled.
    always @(posedge clk) begin
        if (resetn && pkt_valid && pkt_ready) hs_q.push_back(pkt_data);
        if (resetn && prev_stall && (pkt_data !== prev_data)) stall_viol++;
        prev_stall <= resetn && pkt_valid && !pkt_ready;
        prev_data  <= pkt_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic brk);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        rx_break = brk;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_break = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int base_chk, base_len, base_to, base_brk, base_valid, hs_base, k, errs;
        resetn = 1'b0; ctrl_en = 1'b0; rx_valid = 1'b0; rx_data = 8'd0;
        rx_break = 1'b0; pkt_ready = 1'b1;
        idle(2);
        check("reset_outs", {rx_en, pkt_valid, pkt_last, err_chk, err_len, err_timeout, err_break},
              32'd0);
        check("reset_words", {pkt_data, pkt_len, pkt_ok_cnt}, 32'd0);

        resetn = 1'b1;
        idle(1);
        check("idle_rx_en", rx_en, 1'b0);
        ctrl_en = 1'b1;
        idle(1);
        check("hunt_rx_en", rx_en, 1'b1);

        // Good frame, consumer always ready.
        send(8'hA5, 1'b0); send(8'h03, 1'b0); send(8'h11, 1'b0); send(8'h22, 1'b0);
        send(8'h33, 1'b0); send(8'h03, 1'b0);
        check("good_b0", {pkt_valid, pkt_last, pkt_data}, {1'b1, 1'b0, 8'h11});
        check("good_len", pkt_len, 8'd3);
        check("good_cnt", pkt_ok_cnt, 8'd1);
        check("drain_rx_en", rx_en, 1'b0);
        idle(1);
        check("good_b1", {pkt_valid, pkt_last, pkt_data}, {1'b1, 1'b0, 8'h22});
        idle(1);
        check("good_b2", {pkt_valid, pkt_last, pkt_data}, {1'b1, 1'b1, 8'h33});
        idle(1);
        check("good_end", {pkt_valid, rx_en}, {1'b0, 1'b1});

        // Same frame with the consumer toggling ready.
        pkt_ready = 1'b0;
        hs_base = hs_q.size();
        send(8'hA5, 1'b0); send(8'h03, 1'b0); send(8'h11, 1'b0); send(8'h22, 1'b0);
        send(8'h33, 1'b0); send(8'h03, 1'b0);
        check("bp_first", {pkt_valid, pkt_data}, {1'b1, 8'h11});
        repeat (12) begin
            @(negedge clk);
            pkt_ready = ~pkt_ready;
        end
        pkt_ready = 1'b1;
        idle(1);
        check("bp_hs_count", hs_q.size() - hs_base, 32'd3);
        if (hs_q.size() - hs_base == 3) begin
            check("bp_hs_data", {hs_q[hs_base], hs_q[hs_base + 1], hs_q[hs_base + 2]}, 24'h112233);
        end
        check("bp_stable", stall_viol, 32'd0);
        check("bp_done", {pkt_valid, pkt_ok_cnt}, {1'b0, 8'd2});

        // Bad checksum (expected FD), zero length, over-long length.
        base_chk = n_chk; base_len = n_len; base_valid = n_valid;
        send(8'hA5, 1'b0); send(8'h02, 1'b0); send(8'hAA, 1'b0); send(8'h55, 1'b0);
        send(8'h00, 1'b0);
        idle(1);
        check("chk_err", n_chk - base_chk, 32'd1);
        send(8'hA5, 1'b0); send(8'h00, 1'b0);
        idle(1);
        send(8'hA5, 1'b0); send(8'h11, 1'b0);
        idle(1);
        check("len_err", n_len - base_len, 32'd2);
        check("bad_no_valid", n_valid - base_valid, 32'd0);
        check("bad_cnt", pkt_ok_cnt, 8'd2);

        // Inter-byte timeout, then a good one-byte frame.
        base_to = n_to;
        send(8'hA5, 1'b0); send(8'h02, 1'b0); send(8'hAA, 1'b0);
        k = 0;
        while (!err_timeout && k < 3 * TO) begin
            @(negedge clk);
            k++;
        end
        check("timeout_cycles", k, TO);
        idle(1);
        check("timeout_pulse", n_to - base_to, 32'd1);
        send(8'hA5, 1'b0); send(8'h01, 1'b0); send(8'h7E, 1'b0); send(8'h7F, 1'b0);
        check("after_to", {pkt_valid, pkt_last, pkt_data, pkt_len}, {1'b1, 1'b1, 8'h7E, 8'd1});
        check("after_to_cnt", pkt_ok_cnt, 8'd3);
        idle(1);
        check("after_to_end", pkt_valid, 1'b0);

        // BREAK inside payload, then junk before sync.
        base_brk = n_brk; base_chk = n_chk; base_len = n_len;
        send(8'hA5, 1'b0); send(8'h02, 1'b0); send(8'h33, 1'b1);
        idle(1);
        check("break_err", n_brk - base_brk, 32'd1);
        check("break_exclusive", (n_chk - base_chk) + (n_len - base_len), 32'd0);
        check("break_hunt", {rx_en, pkt_valid}, {1'b1, 1'b0});
        send(8'h00, 1'b0); send(8'hFF, 1'b0); send(8'h5A, 1'b0);
        send(8'hA5, 1'b0); send(8'h02, 1'b0); send(8'h10, 1'b0); send(8'h20, 1'b0);
        send(8'h32, 1'b0);
        check("junk_b0", {pkt_valid, pkt_data, pkt_len}, {1'b1, 8'h10, 8'd2});
        idle(1);
        check("junk_b1", {pkt_valid, pkt_last, pkt_data}, {1'b1, 1'b1, 8'h20});
        idle(1);
        check("junk_cnt", {pkt_valid, pkt_ok_cnt}, {1'b0, 8'd4});

        // Enable dropped mid-payload: silent return to idle.
        errs = n_chk + n_len + n_to + n_brk;
        send(8'hA5, 1'b0); send(8'h03, 1'b0); send(8'h01, 1'b0);
        ctrl_en = 1'b0;
        idle(1);
        check("en_drop_rx_en", rx_en, 1'b0);
        idle(2 * TO);
        check("en_drop_no_err", n_chk + n_len + n_to + n_brk - errs, 32'd0);
        ctrl_en = 1'b1;

        // Async reset while a frame is stalled in drain.
        pkt_ready = 1'b0;
        send(8'hA5, 1'b0); send(8'h01, 1'b0); send(8'h42, 1'b0); send(8'h43, 1'b0);
        check("pre_rst_valid", {pkt_valid, pkt_data}, {1'b1, 8'h42});
        #2 resetn = 1'b0;
        #1;
        check("async_rst_outs", {rx_en, pkt_valid, pkt_last, err_chk, err_len, err_timeout, err_break},
              32'd0);
        check("async_rst_words", {pkt_data, pkt_len, pkt_ok_cnt}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
